// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP add/sub finalize stage: operand classes,
// special-value encodings as functions of the field widths, and flag bit positions.
package fpu_pkg;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    INF    = 2'd1,
    NAN    = 2'd2,
    FINITE = 2'd3
  } fp_class_e;

  localparam int FLAG_NAN_IN   = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_W        = 3;

  // Canonical NaN: sign 0, exponent and mantissa all ones.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    return (64'd1 << (exp_w + man_w)) - 64'd1;
  endfunction

  // Positive infinity: exponent all ones, mantissa zero.
  function automatic logic [63:0] pos_inf(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classification of an IEEE754 magnitude (sign excluded) into
// zero / infinity / NaN / finite. Subnormals count as finite.
module fp_classify
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] i_mag,
  output fp_class_e              o_class
);

  logic w_exp_ones;
  logic w_exp_zero;
  logic w_man_zero;

  assign w_exp_ones = &i_mag[EXP_W+MAN_W-1:MAN_W];
  assign w_exp_zero = ~|i_mag[EXP_W+MAN_W-1:MAN_W];
  assign w_man_zero = ~|i_mag[MAN_W-1:0];

  always_comb begin
    o_class = FINITE;
    if (w_exp_ones) begin
      o_class = w_man_zero ? INF : NAN;
    end else if (w_exp_zero && w_man_zero) begin
      o_class = ZERO;
    end
  end

endmodule

// File: rtl/fpu_addsub_finalize.sv
// Two-stage valid/ready finalize for FP add/sub: S1 classifies and holds operands,
// S2 picks the special-case or datapath result. Flag outputs exist with FPU_FLAGS_EN.
module fpu_addsub_finalize
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] temp_result,
  input  logic [1:0]   qualon,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result
`ifdef FPU_FLAGS_EN
  ,
  output logic [FLAG_W-1:0] flags
`endif
);

  localparam logic [63:0]  C_NAN64 = canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0] C_NAN   = C_NAN64[W-1:0];

  fp_class_e w_cls1;
  fp_class_e w_cls2;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls1 (
    .i_mag   (in1[W-2:0]),
    .o_class (w_cls1)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls2 (
    .i_mag   (in2[W-2:0]),
    .o_class (w_cls2)
  );

  logic         r_s1_full;
  logic [W-1:0] r_s1_in1;
  logic [W-1:0] r_s1_in2;
  logic [W-1:0] r_s1_temp;
  logic [1:0]   r_s1_qualon;
  fp_class_e    r_s1_cls1;
  fp_class_e    r_s1_cls2;

  logic         r_s2_full;
  logic [W-1:0] r_result;

  logic         w_s1_adv;
  logic         w_bypass;
  logic         w_any_nan;
  logic         w_both_inf;
  logic         w_sign_diff;
  logic [W-1:0] w_sel;

  // S1 moves forward whenever S2 is empty or is being drained this cycle.
  assign w_s1_adv  = !r_s2_full || out_ready;
  assign in_ready  = !r_s1_full || w_s1_adv;
  assign out_valid = r_s2_full;
  assign result    = r_result;

  assign w_bypass    = r_s1_qualon[0];
  assign w_any_nan   = (r_s1_cls1 == NAN) || (r_s1_cls2 == NAN);
  assign w_both_inf  = (r_s1_cls1 == INF) && (r_s1_cls2 == INF);
  assign w_sign_diff = r_s1_in1[W-1] ^ r_s1_in2[W-1];

  always_comb begin
    w_sel = r_s1_temp;
    if (w_bypass) begin
      w_sel = r_s1_qualon[1] ? r_s1_in2 : r_s1_in1;
    end else if (w_any_nan) begin
      w_sel = C_NAN;
    end else if (w_both_inf) begin
      w_sel = w_sign_diff ? C_NAN : r_s1_in1;
    end else if (r_s1_cls1 == INF) begin
      w_sel = r_s1_in1;
    end else if (r_s1_cls2 == INF) begin
      w_sel = r_s1_in2;
    end else if ((r_s1_cls1 == ZERO) && (r_s1_cls2 == ZERO)) begin
      w_sel = {r_s1_in1[W-1] & r_s1_in2[W-1], {(W-1){1'b0}}};
    end else if (r_s1_cls1 == ZERO) begin
      w_sel = r_s1_in2;
    end else if (r_s1_cls2 == ZERO) begin
      w_sel = r_s1_in1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_full <= 1'b0;
    end else if (in_ready) begin
      r_s1_full <= in_valid;
    end
  end

  // Operand payload needs no reset: it is only observed behind r_s1_full.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r_s1_in1    <= in1;
      r_s1_in2    <= in2;
      r_s1_temp   <= temp_result;
      r_s1_qualon <= qualon;
      r_s1_cls1   <= w_cls1;
      r_s1_cls2   <= w_cls2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_full <= 1'b0;
      r_result  <= '0;
    end else if (w_s1_adv) begin
      r_s2_full <= r_s1_full;
      if (r_s1_full) begin
        r_result <= w_sel;
      end
    end
  end

`ifdef FPU_FLAGS_EN
  localparam logic [63:0]  C_INF64 = pos_inf(EXP_W, MAN_W);
  localparam logic [W-1:0] C_INF   = C_INF64[W-1:0];

  logic              w_snan;
  logic              w_temp_inf;
  logic              w_temp_chosen;
  logic [FLAG_W-1:0] w_flags;
  logic [FLAG_W-1:0] r_flags;

  // Signalling NaN: quiet bit (mantissa MSB) clear; NaN class already guarantees nonzero mantissa.
  assign w_snan = ((r_s1_cls1 == NAN) && !r_s1_in1[MAN_W-1]) ||
                  ((r_s1_cls2 == NAN) && !r_s1_in2[MAN_W-1]);
  assign w_temp_inf    = (r_s1_temp[W-2:0] == C_INF[W-2:0]);
  assign w_temp_chosen = !w_bypass && (r_s1_cls1 == FINITE) && (r_s1_cls2 == FINITE);

  always_comb begin
    w_flags                = '0;
    w_flags[FLAG_INVALID]  = !w_bypass && ((w_both_inf && w_sign_diff) || w_snan);
    w_flags[FLAG_OVERFLOW] = w_temp_chosen && w_temp_inf;
    w_flags[FLAG_NAN_IN]   = !w_bypass && w_any_nan;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_s1_adv && r_s1_full) begin
      r_flags <= w_flags;
    end
  end

  assign flags = r_flags;
`endif

endmodule

// File: tb/tb_fpu_addsub_finalize.sv
// Randomized and directed bench for fpu_addsub_finalize (W=32) against a field-level
// reference model and an in-order scoreboard; flag checks compile in with FPU_FLAGS_EN.
module tb_fpu_addsub_finalize;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [W-1:0] temp_result = '0;
  logic [1:0]   qualon = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
`ifdef FPU_FLAGS_EN
  logic [2:0]   flags;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flg;   // {invalid, overflow, nan_in}
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fpu_addsub_finalize #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in1         (in1),
    .in2         (in2),
    .temp_result (temp_result),
    .qualon      (qualon),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result)
`ifdef FPU_FLAGS_EN
    ,
    .flags       (flags)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  // Reference: IEEE754 single-precision special-case rules on raw fields.
  function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] t, input logic [1:0] q);
    exp_t e;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan, t_inf;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_zero = (a[30:0] == 0);
    b_zero = (b[30:0] == 0);
    a_snan = a_nan && !a[22];
    b_snan = b_nan && !b[22];
    t_inf  = (t[30:23] == 8'hFF) && (t[22:0] == 0);
    e.flg = 3'b000;
    if (q[0]) begin
      e.res = q[1] ? b : a;
    end else begin
      e.flg[0] = a_nan || b_nan;
      e.flg[2] = a_snan || b_snan || (a_inf && b_inf && (a[31] != b[31]));
      if (a_nan || b_nan)        e.res = 32'h7FFF_FFFF;
      else if (a_inf && b_inf)   e.res = (a[31] != b[31]) ? 32'h7FFF_FFFF : a;
      else if (a_inf)            e.res = a;
      else if (b_inf)            e.res = b;
      else if (a_zero && b_zero) e.res = (a[31] && b[31]) ? 32'h8000_0000 : 32'h0000_0000;
      else if (a_zero)           e.res = b;
      else if (b_zero)           e.res = a;
      else begin
        e.res    = t;
        e.flg[1] = t_inf;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    logic       s;
    logic [3:0] k;
    s = 1'($urandom);
    k = 4'($urandom_range(0, 9));
    case (k)
      4'd0:    return {s, 31'h0};
      4'd1:    return {s, 8'hFF, 23'h0};
      4'd2:    return {s, 8'hFF, 1'b1, 22'($urandom)};
      4'd3:    return {s, 8'hFF, 1'b0, 22'($urandom) | 22'h1};
      4'd4:    return {s, 8'h00, 23'($urandom) | 23'h1};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // One clock: drive at the falling edge, evaluate handshakes 1ns later.
  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] t, input logic [1:0] q, input bit ordy,
                       output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid = v; in1 = a; in2 = b; temp_result = t; qualon = q; out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) sb.push_back(ref_model(a, b, t, q));
    if (out_valid && out_ready) begin
      check("out_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
`ifdef FPU_FLAGS_EN
        check("flags", 64'(flags), 64'(e.flg));
`endif
      end
    end
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 2'b00, ordy, acc);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1'b1);
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    int n_acc;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
`ifdef FPU_FLAGS_EN
    check("rst_flags", 64'(flags), 64'd0);
`endif
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Ordinary sum and two-cycle latency
    cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 2'b00, 1'b1, acc);
    check("lat_accept", 64'(acc), 64'd1);
    idle(1'b1);
    check("lat_n1_valid", 64'(out_valid), 64'd0);
    idle(1'b1);
    check("lat_n2_valid", 64'(out_valid), 64'd1);
    check("lat_n2_result", 64'(result), 64'h4040_0000);
    drain("drain_basic");

    // Directed special cases
    cycle(1'b1, 32'h7F80_0000, 32'hFF80_0000, 32'h1234_0000, 2'b00, 1'b1, acc);
    cycle(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h5555_0000, 2'b00, 1'b1, acc);
    cycle(1'b1, 32'h0000_0000, 32'h8000_0000, 32'h5555_0000, 2'b00, 1'b1, acc);
    cycle(1'b1, 32'h7FC0_0000, 32'h1234_5678, 32'h0000_0001, 2'b11, 1'b1, acc);
    cycle(1'b1, 32'h7F80_0000, 32'h7F80_0000, 32'h0000_0001, 2'b00, 1'b1, acc);
    cycle(1'b1, 32'h0000_0000, 32'hC000_0000, 32'h0000_0001, 2'b00, 1'b1, acc);
    cycle(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000, 2'b00, 1'b1, acc);
    cycle(1'b1, 32'h7F80_0001, 32'h3F80_0000, 32'h0000_0001, 2'b01, 1'b1, acc);
    drain("drain_directed");

    // Stream of 8 with out_ready low for the first 3 cycles
    n_acc = 0;
    for (int c = 0; c < 40 && n_acc < 8; c++) begin
      cycle(1'b1, rand_op(), rand_op(), {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)},
            2'b00, c >= 3, acc);
      if (acc) n_acc++;
      if (c == 2) begin
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_accepted", 64'(n_acc), 64'd2);
      end
    end
    check("stream_count", 64'(n_acc), 64'd8);
    drain("drain_stream");

    // Reset with both stages full discards in-flight work
    cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'hAAAA_0000, 2'b00, 1'b0, acc);
    cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'hBBBB_0000, 2'b00, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 2'b00, 1'b1, acc);
    idle(1'b1);
    idle(1'b1);
    check("midrst_first_out", 64'(result), 64'h4080_0000);
    drain("drain_midrst");

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      cycle(1'($urandom), rand_op(), rand_op(), rand_op(), 2'($urandom),
            $urandom_range(0, 9) < 7, acc);
    end
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
